rfft_seq_ctrl: RTL

- Parametrised control/address sequencer for the 4-lane rfft_4pt datapath.
- Replaces the hand-coded per-stage control previously scattered across benches.
- Runs a load phase that fills the four data banks, then ADDR_BIT+1 compute stages.
- Per stage it generates bank addresses with per-stage rotation, twiddle addresses, bypass and pair-select controls, and pipeline-delayed write-back.
- Start/busy/done handshake toward the host, valid/ready toward the sample source.

---
 rtl/rfft_seq_ctrl_if.sv | 37 +++
 rtl/rfft_seq_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/rfft_seq_ctrl_if.sv
`timescale 1ns/1ps
// rfft_seq_ctrl_if: host handshake, sample-source handshake and bank/twiddle control bundle
// between rfft_seq_ctrl (master) and the host/rfft_4pt datapath (slave).
interface rfft_seq_ctrl_if #(
    parameter int N        = 32,
    parameter int ADDR_BIT = 3
);
    localparam int TW_W = $clog2(N / 2);

    logic                    start;
    logic                    busy;
    logic                    done;
    logic                    start_err;
    logic                    ld_valid;
    logic                    ld_ready;
    logic                    load_mode;
    logic [ADDR_BIT:0]       stage;
    logic                    rd_en;
    logic [4*ADDR_BIT-1:0]   rd_addr;
    logic                    wr_en;
    logic [4*ADDR_BIT-1:0]   wr_addr;
    logic [TW_W-1:0]         tw_addr;
    logic                    bypass_en;
    logic                    pair_sel;

    modport master (
        input  start, ld_valid,
        output busy, done, start_err, ld_ready, load_mode, stage,
               rd_en, rd_addr, wr_en, wr_addr, tw_addr, bypass_en, pair_sel
    );

    modport slave (
        output start, ld_valid,
        input  busy, done, start_err, ld_ready, load_mode, stage,
               rd_en, rd_addr, wr_en, wr_addr, tw_addr, bypass_en, pair_sel
    );
endinterface

// File: rtl/rfft_seq_ctrl.sv
`timescale 1ns/1ps
// rfft_seq_ctrl: load phase plus ADDR_BIT+1 compute stages of bank/twiddle sequencing for rfft_4pt.
// Define RFFT_SEQ_START_ERR_EN to build the sticky start_err flag; otherwise start_err is 0.
module rfft_seq_ctrl #(
    parameter int N        = 32,
    parameter int ADDR_BIT = 3,
    parameter int PIPE_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    rfft_seq_ctrl_if.master bus
);
    localparam int AW4  = 4 * ADDR_BIT;
    localparam int TW_W = $clog2(N / 2);
    localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ADDR_BIT:0]   MH_V     = {1'b1, {ADDR_BIT{1'b0}}};
    localparam logic [ADDR_BIT:0]   K_LAST   = (ADDR_BIT + 1)'(ADDR_BIT);
    localparam logic [ADDR_BIT-1:0] CNT_LAST = '1;
    localparam logic [DW-1:0]       D_LAST   = DW'(PIPE_LAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    logic [2:0]          state;
    logic [ADDR_BIT-1:0] cnt;
    logic [ADDR_BIT:0]   k;
    logic [DW-1:0]       dcnt;

    logic                rd_en;
    logic [AW4-1:0]      rd_addr;
    logic [TW_W-1:0]     tw;
    logic                byp;
    logic                psel;
    logic [ADDR_BIT:0]   off;
    logic [ADDR_BIT:0]   psh;
    logic [ADDR_BIT-1:0] rot;
    logic [ADDR_BIT-1:0] cnt_sh;

    logic [PIPE_LAT-1:0] vld_p;
    logic [AW4-1:0]      wr_addr_p [PIPE_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            k     <= '0;
            dcnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state <= S_LOAD;
                        cnt   <= '0;
                        k     <= '0;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= S_RUN;
                            k     <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // cnt wraps back to 0 on the last read, ready for the next stage
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= S_DRAIN;
                        dcnt  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (dcnt == D_LAST) begin
                        if (k == K_LAST) begin
                            state <= S_FIN;
                        end else begin
                            k     <= k + 1'b1;
                            state <= S_RUN;
                        end
                    end else begin
                        dcnt <= dcnt + 1'b1;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    k     <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Read side: bank 2/3 rotation, twiddle stride and pair select from (cnt, k)
    always_comb begin
        off     = MH_V - (MH_V >> k);
        rot     = cnt + off[ADDR_BIT-1:0];
        psh     = K_LAST - k - 1'b1;
        cnt_sh  = cnt >> psh;
        rd_en   = (state == S_RUN);
        rd_addr = '0;
        tw      = '0;
        byp     = 1'b0;
        psel    = 1'b0;
        if (rd_en) begin
            rd_addr = {rot, rot, cnt, cnt};
            tw      = TW_W'(cnt) << k;
            byp     = (k < K_LAST);
            psel    = (k < K_LAST) ? cnt_sh[0] : 1'b0;
        end
    end

    // Stage p0..pN: write-back delay line matching the datapath read-to-write latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p <= '0;
            for (int i = 0; i < PIPE_LAT; i++) wr_addr_p[i] <= '0;
        end else begin
            vld_p[0]     <= rd_en;
            wr_addr_p[0] <= rd_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_p[i]     <= vld_p[i-1];
                wr_addr_p[i] <= wr_addr_p[i-1];
            end
        end
    end

    always_comb begin
        if (state == S_LOAD) begin
            bus.wr_en   = bus.ld_valid;
            bus.wr_addr = {4{cnt}};
        end else begin
            bus.wr_en   = vld_p[PIPE_LAT-1];
            bus.wr_addr = wr_addr_p[PIPE_LAT-1];
        end
    end

    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = (state == S_FIN);
    assign bus.ld_ready  = (state == S_LOAD);
    assign bus.load_mode = (state == S_LOAD);
    assign bus.stage     = k;
    assign bus.rd_en     = rd_en;
    assign bus.rd_addr   = rd_addr;
    assign bus.tw_addr   = tw;
    assign bus.bypass_en = byp;
    assign bus.pair_sel  = psel;

`ifdef RFFT_SEQ_START_ERR_EN
    logic start_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            start_err_q <= 1'b0;
        end else if (bus.start) begin
            start_err_q <= (state != S_IDLE);
        end
    end

    assign bus.start_err = start_err_q;
`else
    assign bus.start_err = 1'b0;
`endif
endmodule
